mult_div_unit: RTL and testbench

Iterative-latency multiply/divide responder behind the execute stage's `start`/`busy` handshake. Accepts one MULT/MULTU/DIV/DIVU command per `start` pulse, holds `busy` for the fixed operation latency, then commits the result to architectural HI/LO registers. Also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_signed_div.sv | 38 +++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU opcode encodings, default latencies and small decode helpers.
// Imported by mult_div_unit, mdu_signed_div and the execute-stage controller.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    localparam int unsigned MDU_MULT_CYCLES = 32'd5;
    localparam int unsigned MDU_DIV_CYCLES  = 32'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic mdu_op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mdu_signed_div.sv
// Combinational 32-bit divider: magnitude divide with sign correction,
// plus divide-by-zero and signed-overflow (0x80000000 / -1) flags.
module mdu_signed_div
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o,
    output logic        div_zero_o,
    output logic        ovf_o
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] divisor_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    // Magnitude divide; the divisor is forced non-zero so the divide stays defined.
    always_comb begin
        a_neg_s    = signed_i & a_i[31];
        b_neg_s    = signed_i & b_i[31];
        a_mag_s    = a_neg_s ? (32'd0 - a_i) : a_i;
        b_mag_s    = b_neg_s ? (32'd0 - b_i) : b_i;
        div_zero_o = (b_i == 32'd0);
        divisor_s  = div_zero_o ? 32'd1 : b_mag_s;
        q_mag_s    = a_mag_s / divisor_s;
        r_mag_s    = a_mag_s % divisor_s;
        quo_o      = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_o      = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
        ovf_o      = signed_i & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
    end

endmodule

// File: rtl/mult_div_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic        HIWr,
    input  logic        LOWr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = ($clog2(MAX_LAT + 32'd1) > 4) ? $clog2(MAX_LAT + 32'd1) : 4;

    mdu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_n_q;
    logic [31:0]       lo_n_q;
    logic              commit_q;

    logic              op_signed_s;
    logic [63:0]       a_ext_s;
    logic [63:0]       b_ext_s;
    logic [63:0]       prod_s;
    logic [31:0]       quo_s;
    logic [31:0]       rem_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              op_valid_s;
    logic              commit_en_s;
    logic [63:0]       res_s;
    logic [CNT_W-1:0]  lat_s;

    mdu_signed_div u_div (
        .a_i        (A),
        .b_i        (B),
        .signed_i   (op_signed_s),
        .quo_o      (quo_s),
        .rem_o      (rem_s),
        .div_zero_o (div_zero_s),
        .ovf_o      (ovf_s)
    );

    // Operand extension: the low 64 bits of a 64x64 product are exact for both signednesses.
    always_comb begin
        op_signed_s = mdu_op_is_signed(MDUOp);
        a_ext_s     = {{32{op_signed_s & A[31]}}, A};
        b_ext_s     = {{32{op_signed_s & B[31]}}, B};
        prod_s      = a_ext_s * b_ext_s;
    end

    // Result, latency and commit-enable selection for the command presented with start.
    always_comb begin
        op_valid_s  = 1'b0;
        commit_en_s = 1'b1;
        res_s       = 64'd0;
        lat_s       = CNT_W'(MULT_CYCLES);
        case (MDUOp)
            MDU_MULT, MDU_MULTU: begin
                op_valid_s = 1'b1;
                res_s      = prod_s;
            end
            MDU_DIV, MDU_DIVU: begin
                op_valid_s  = 1'b1;
                commit_en_s = ~div_zero_s;
                lat_s       = CNT_W'(DIV_CYCLES);
                res_s       = ovf_s ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
                op_valid_s = 1'b1;
                res_s      = {hi_q, lo_q} + prod_s;
            end
            MDU_MSUB, MDU_MSUBU: begin
                op_valid_s = 1'b1;
                res_s      = {hi_q, lo_q} - prod_s;
            end
`endif
            default: begin
                op_valid_s = 1'b0;
            end
        endcase
    end

    // Control FSM, latency counter, shadow result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_n_q   <= 32'd0;
            lo_n_q   <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // start wins over MTHI/MTLO even when the op itself is reserved
                        if (op_valid_s) begin
                            hi_n_q   <= res_s[63:32];
                            lo_n_q   <= res_s[31:0];
                            commit_q <= commit_en_s;
                            cnt_q    <= lat_s;
                            busy_q   <= 1'b1;
                            state_q  <= ST_RUN;
                        end
                    end else begin
                        if (HIWr) begin
                            hi_q <= A;
                        end
                        if (LOWr) begin
                            lo_q <= A;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (commit_q) begin
                            hi_q <= hi_n_q;
                            lo_q <= lo_n_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed/scoreboard testbench for mult_div_unit; honours MDU_MADD_EN if defined.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  MDUOp;
    logic        HIWr;
    logic        LOWr;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDUOp (MDUOp),
        .HIWr  (HIWr),
        .LOWr  (LOWr),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sbv;
        logic [63:0] p_s, p_u;
        int qi, ri;
        sa  = $signed(a);
        sbv = $signed(b);
        p_s = sa * sbv;
        p_u = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0: return p_s;
            3'd1: return p_u;
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = $signed(a) / $signed(b);
                ri = $signed(a) % $signed(b);
                return {ri, qi};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            3'd4: return {hi, lo} + p_s;
            3'd5: return {hi, lo} + p_u;
            3'd6: return {hi, lo} - p_s;
            default: return {hi, lo} - p_u;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] v);
        @(negedge clk);
        HIWr = h; LOWr = l; A = v;
        @(negedge clk);
        HIWr = 1'b0; LOWr = 1'b0;
        if (h) hi_m = v;
        if (l) lo_m = v;
        check("mt_hi", HI, hi_m);
        check("mt_lo", LO, lo_m);
    endtask

    // extra[0]: HIWr alongside start; extra[1]: LOWr pulse during busy
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] extra);
        int n;
        int lat;
        logic [63:0] exp;
        lat = (op == 3'd2 || op == 3'd3) ? 10 : 5;
        @(negedge clk);
        MDUOp = op; A = a; B = b; start = 1'b1; HIWr = extra[0];
        sb.push_back(model(op, a, b, hi_m, lo_m));
        @(negedge clk);
        start = 1'b0; HIWr = 1'b0; A = 32'hDEAD_BEEF;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            LOWr = (n == 1) && extra[1];
            n++;
            @(negedge clk);
        end
        LOWr = 1'b0;
        check({tag, "_busy_cycles"}, n, lat);
        exp = sb.pop_front();
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        check({tag, "_hi"}, HI, hi_m);
        check({tag, "_lo"}, LO, lo_m);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MDUOp = 3'd0; HIWr = 1'b0; LOWr = 1'b0;
        A = 32'd0; B = 32'd0;
        do_reset();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 2'b00);
        check("mult_neg_lit_hi", HI, 32'hFFFF_FFFF);
        check("mult_neg_lit_lo", LO, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 2'b00);
        check("multu_lit_hi", HI, 32'h0000_0002);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 2'b00);
        check("div_neg_lit_lo", LO, 32'hFFFF_FFFD);
        check("div_neg_lit_hi", HI, 32'hFFFF_FFFF);
        run_op("divu", 3'd3, 32'd7, 32'd2, 2'b00);
        check("divu_lit_lo", LO, 32'd3);

        mt_write(1'b1, 1'b0, 32'h1234_5678);
        run_op("div_zero", 3'd2, 32'd55, 32'd0, 2'b00);
        check("div_zero_lit_hi", HI, 32'h1234_5678);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

        run_op("start_vs_wr", 3'd0, 32'd5, 32'd6, 2'b11);
        check("start_vs_wr_lit_lo", LO, 32'd30);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] op;
            logic [31:0] ra, rb;
            op = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op($sformatf("rand%0d", i), op, ra, rb, 2'b00);
        end

        // reset in the middle of a divide
        @(negedge clk);
        MDUOp = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_late_hi", HI, 32'd0);
        check("midrst_late_lo", LO, 32'd0);

        mt_write(1'b1, 1'b0, 32'd0);
        mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", 3'd5, 32'd1, 32'd1, 2'b00);
        check("maddu_lit_hi", HI, 32'd1);
        check("maddu_lit_lo", LO, 32'd0);
        run_op("msub", 3'd6, 32'd3, 32'hFFFF_FFFF, 2'b00);
`else
        @(negedge clk);
        MDUOp = 3'd5; A = 32'd1; B = 32'd1; start = 1'b1; HIWr = 1'b1;
        @(negedge clk);
        start = 1'b0; HIWr = 1'b0;
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("rsvd_busy_late", {31'd0, busy}, 32'd0);
        check("rsvd_hi", HI, 32'd0);
        check("rsvd_lo", LO, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
